hazard_scoreboard: RTL
======================

// Module: hazard_scoreboard
// PURPOSE
// Hazard controller for the ID-stage register file in the 5-stage pipeline.
// - Tracks the destination registers of in-flight instructions in EX, MEM and WB.
// - Decides when the ID instruction must stall.
// - Drives the EX-stage operand forwarding selects and the WB->ID same-cycle bypass.
// - Counts stall cycles for performance measurement.
// PARAMETERS
// FORWARD   1   1: forwarding on, only load-use stalls; 0: stall on any in-flight RAW
// CNT_W     16  width of the saturating stall counter
// PORTS
// clk           in   1      pipeline clock, all state on posedge
// reset         in   1      asynchronous, active-high; clears all state
// id_valid      in   1      ID holds a real instruction
// id_rs         in   5      instru[25:21] of the ID instruction
// id_rt         in   5      instru[20:16] of the ID instruction
// id_uses_rs    in   1      ID instruction reads rs
// id_uses_rt    in   1      ID instruction reads rt
// id_dest       in   5      resolved destination (rt or rd, per RegDst)
// id_regwrite   in   1      ID instruction writes the register file
// id_is_load    in   1      ID instruction is lw
// flush         in   1      branch taken: kill the ID instruction this cycle
// stall         out  1      hold PC/IF-ID and insert a bubble into EX
// fwd_a         out  2      EX operand A: 00 regfile, 01 EX/MEM result, 10 MEM/WB result
// fwd_b         out  2      EX operand B: same encoding as fwd_a
// id_bypass_a   out  1      ID rs read takes WriteData (WB writes it this cycle)
// id_bypass_b   out  1      ID rt read takes WriteData
// stall_count   out  CNT_W  number of cycles with stall=1; saturates at all-ones
// BEHAVIOUR
// State: three slot registers EX, MEM, WB.
// - Each slot holds {valid, regwrite, is_load, dest[4:0]}.
// - The EX slot additionally holds rs[4:0], rt[4:0], uses_rs and uses_rt.
// Reset: all slots cleared (valid=0); stall_count=0.
// Reset output values: stall=0, fwd_a=fwd_b=00, id_bypass_a=id_bypass_b=0.
// Reset mid-operation: all in-flight entries are dropped immediately; no stall survives reset.
// Writer definition: slot S "writes r" = S.valid & S.regwrite & (S.dest != 0) & (S.dest == r).
// - Register $0 never causes a hazard, forward or bypass.
// Source match: "ID needs r" = id_valid & ((id_uses_rs & id_rs == r) | (id_uses_rt & id_rt == r)).
// Stall, combinational from current state and ID inputs:
// - FORWARD=1: stall = ~flush & (EX.is_load & EX writes a source ID needs).
// - FORWARD=0: stall = ~flush & (EX, MEM or WB writes a source ID needs).
//   - WB is included in this case because the register file reads combinationally
//     and writes on posedge.
// - flush has priority over stall: on a simultaneous event, stall=0 and the
//   instruction is killed.
// Slot update every posedge (no external enable):
// - WB <= MEM; MEM <= EX.
// - EX <= bubble (valid=0) if stall | flush | ~id_valid.
// - Otherwise EX <= ID fields.
// - A stalled instruction re-presents in ID next cycle. With FORWARD=1 a load-use
//   stall lasts exactly 1 cycle.
// Forwarding selects (combinational, FORWARD=1 only; tied to 00 when FORWARD=0):
// - fwd_a = 01 if MEM writes EX.rs & EX.uses_rs & EX.valid.
// - else fwd_a = 10 if WB writes EX.rs & EX.uses_rs & EX.valid.
// - else fwd_a = 00.
// - MEM has priority over WB, so the youngest value wins.
// - fwd_b is the same rule using EX.rt and EX.uses_rt.
// ID bypass (FORWARD=1 only, else 0):
// - id_bypass_a = WB writes id_rs & id_valid & id_uses_rs.
// - id_bypass_b is the same rule with rt.
// stall_count increments on every posedge where stall=1.
// - It holds at 2^CNT_W-1; it never wraps.
// TESTING
// 1. lw $2 into EX while ID add $3,$2,$4 (uses rs,rt), FORWARD=1 -> stall=1 one cycle.
//    Next cycle: bubble in EX, stall=0, fwd_a=10 when the add reaches EX.
// 2. add $5 in MEM, add $5 in WB, EX sub rs=$5 -> fwd_a=01 (MEM priority).
//    Then with the MEM slot as a bubble -> fwd_a=10.
// 3. lw $0 in EX, ID uses $0 -> stall=0, fwd=00, bypass=0.
// 4. Load-use hazard present and flush=1 in the same cycle -> stall=0.
//    Next cycle: EX.valid=0, stall_count unchanged.
// 5. FORWARD=0, add $7 issued, dependent ID instruction -> stall=1 for exactly 3 cycles.
//    stall_count +3.
// 6. Force stall_count to 16'hFFFE, hold stall 3 cycles -> stall_count=16'hFFFF.
//    Assert reset mid-stall -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/hazard_scoreboard_if.sv
// rtl/hazard_scoreboard_if.sv - ID-stage hazard interface between the pipeline and the scoreboard
// The pipeline side is the master; the scoreboard is the slave.
interface hazard_scoreboard_if #(
   parameter int CNT_W = 16
);
   logic             id_valid;
   logic [4:0]       id_rs;
   logic [4:0]       id_rt;
   logic             id_uses_rs;
   logic             id_uses_rt;
   logic [4:0]       id_dest;
   logic             id_regwrite;
   logic             id_is_load;
   logic             flush;
   logic             stall;
   logic [1:0]       fwd_a;
   logic [1:0]       fwd_b;
   logic             id_bypass_a;
   logic             id_bypass_b;
   logic [CNT_W-1:0] stall_count;

   modport master (
      output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_dest,
             id_regwrite, id_is_load, flush,
      input  stall, fwd_a, fwd_b, id_bypass_a, id_bypass_b, stall_count
   );

   modport slave (
      input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_dest,
             id_regwrite, id_is_load, flush,
      output stall, fwd_a, fwd_b, id_bypass_a, id_bypass_b, stall_count
   );
endinterface

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - RAW hazard scoreboard: stall, EX forwarding, WB->ID bypass, stall counter
// Tracks EX/MEM/WB destinations; register $0 never participates in any hazard.
module hazard_scoreboard #(
   parameter bit FORWARD = 1'b1,
   parameter int CNT_W   = 16
) (
   input logic                clk,
   input logic                reset,
   hazard_scoreboard_if.slave hz
);
   logic             exValid, exRegWrite, exIsLoad, exUsesRs, exUsesRt;
   logic [4:0]       exDest, exRs, exRt;
   logic             memValid, memRegWrite;
   logic [4:0]       memDest;
   logic             wbValid, wbRegWrite;
   logic [4:0]       wbDest;
   logic [CNT_W-1:0] stallCnt;

   logic             exHit, memHit, wbHit, stallInt;
   logic             memA, memB, wbA, wbB;
   logic [1:0]       fwdA, fwdB;

   function automatic logic writes(input logic v, input logic rw,
                                   input logic [4:0] d, input logic [4:0] r);
      return v & rw & (d != 5'd0) & (d == r);
   endfunction

   // A slot hits when it writes any register the ID instruction actually reads.
   assign exHit  = hz.id_valid &
                   ((hz.id_uses_rs & writes(exValid, exRegWrite, exDest, hz.id_rs)) |
                    (hz.id_uses_rt & writes(exValid, exRegWrite, exDest, hz.id_rt)));
   assign memHit = hz.id_valid &
                   ((hz.id_uses_rs & writes(memValid, memRegWrite, memDest, hz.id_rs)) |
                    (hz.id_uses_rt & writes(memValid, memRegWrite, memDest, hz.id_rt)));
   assign wbHit  = hz.id_valid &
                   ((hz.id_uses_rs & writes(wbValid, wbRegWrite, wbDest, hz.id_rs)) |
                    (hz.id_uses_rt & writes(wbValid, wbRegWrite, wbDest, hz.id_rt)));

   always_comb begin
      stallInt = 1'b0;
      if (FORWARD)
         stallInt = ~hz.flush & exIsLoad & exHit;
      else
         stallInt = ~hz.flush & (exHit | memHit | wbHit);
   end

   assign memA = exValid & exUsesRs & writes(memValid, memRegWrite, memDest, exRs);
   assign memB = exValid & exUsesRt & writes(memValid, memRegWrite, memDest, exRt);
   assign wbA  = exValid & exUsesRs & writes(wbValid, wbRegWrite, wbDest, exRs);
   assign wbB  = exValid & exUsesRt & writes(wbValid, wbRegWrite, wbDest, exRt);

   // MEM is checked first so the youngest producer wins.
   always_comb begin
      fwdA = 2'b00;
      fwdB = 2'b00;
      if (FORWARD) begin
         if (memA)     fwdA = 2'b01;
         else if (wbA) fwdA = 2'b10;
         if (memB)     fwdB = 2'b01;
         else if (wbB) fwdB = 2'b10;
      end
   end

   assign hz.stall       = stallInt;
   assign hz.fwd_a       = fwdA;
   assign hz.fwd_b       = fwdB;
   assign hz.id_bypass_a = FORWARD & hz.id_valid & hz.id_uses_rs &
                           writes(wbValid, wbRegWrite, wbDest, hz.id_rs);
   assign hz.id_bypass_b = FORWARD & hz.id_valid & hz.id_uses_rt &
                           writes(wbValid, wbRegWrite, wbDest, hz.id_rt);
   assign hz.stall_count = stallCnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         exValid     <= 1'b0;
         exRegWrite  <= 1'b0;
         exIsLoad    <= 1'b0;
         exUsesRs    <= 1'b0;
         exUsesRt    <= 1'b0;
         exDest      <= 5'd0;
         exRs        <= 5'd0;
         exRt        <= 5'd0;
         memValid    <= 1'b0;
         memRegWrite <= 1'b0;
         memDest     <= 5'd0;
         wbValid     <= 1'b0;
         wbRegWrite  <= 1'b0;
         wbDest      <= 5'd0;
         stallCnt    <= '0;
      end else begin
         wbValid     <= memValid;
         wbRegWrite  <= memRegWrite;
         wbDest      <= memDest;
         memValid    <= exValid;
         memRegWrite <= exRegWrite;
         memDest     <= exDest;
         // A stalled or flushed instruction becomes a bubble; only valid qualifies the slot.
         exValid     <= hz.id_valid & ~stallInt & ~hz.flush;
         exRegWrite  <= hz.id_regwrite;
         exIsLoad    <= hz.id_is_load;
         exUsesRs    <= hz.id_uses_rs;
         exUsesRt    <= hz.id_uses_rt;
         exDest      <= hz.id_dest;
         exRs        <= hz.id_rs;
         exRt        <= hz.id_rt;
         if (stallInt && (stallCnt != {CNT_W{1'b1}}))
            stallCnt <= stallCnt + 1'b1;
      end
   end
endmodule
